block_dispatcher: RTL and testbench
===================================

// Module: block_dispatcher
// PURPOSE
//   Consumes thread_count from the device control register and splits the kernel into blocks of
//   THREADS_PER_BLOCK threads. Hands blocks to NUM_CORES compute cores, collects completions and
//   raises done when the whole kernel has finished. Sits between the DCR and the core array.
// PARAMETERS
//   NUM_CORES          2  number of compute cores served (1..8)
//   THREADS_PER_BLOCK  4  threads per block; power of two, 1..128
// PORTS
//   clk                input   1                      clock; all state changes on rising edge
//   reset              input   1                      asynchronous, active-low (0 = reset)
//   start              input   1                      kernel launch request (level)
//   thread_count       input   8                      total threads, from DCR
//   core_done          input   NUM_CORES              per-core block-finished (level)
//   core_start         output  NUM_CORES              per-core run; high while block assigned
//   core_reset         output  NUM_CORES              per-core one-cycle clear pulse
//   core_block_id      output  8*NUM_CORES            block index; core i at [8i+7:8i]
//   core_thread_count  output  8*NUM_CORES            threads in block; core i at [8i+7:8i]
//   done               output  1                      kernel complete
// BEHAVIOUR
//   Reset (async, reset==0): state IDLE; all outputs 0; all counters 0; every core marked free.
//   total_blocks = ceil(thread_count / THREADS_PER_BLOCK), 8-bit.
//     - thread_count is latched on the IDLE->RUN edge; later DCR writes are ignored until IDLE.
//   FSM IDLE/RUN/DONE:
//     - IDLE: start==1 -> RUN; latch thread_count; dispatched=0, completed=0.
//     - IDLE: if the latched total_blocks==0, go straight to DONE on the next cycle.
//     - RUN: each cycle, pick the lowest-index free core. If dispatched<total_blocks, assign it:
//       core_start[i]<=1, core_block_id[i]<=dispatched, dispatched++.
//     - RUN: at most one dispatch per cycle. First core_start rises 1 cycle after entering RUN.
//     - RUN: core_thread_count = THREADS_PER_BLOCK, except the last block when there is a
//       remainder: thread_count - block_id*THREADS_PER_BLOCK.
//     - Completion: core_done[i]==1 with core_start[i]==1 -> core_start[i]<=0,
//       core_reset[i]<=1 for exactly 1 cycle, completed++.
//     - The core stays busy during its reset pulse; it is free from the cycle after the pulse.
//     - core_done on a core with core_start==0 is ignored.
//     - Several core_done in the same cycle all count (completed += popcount).
//     - A dispatch and completions in the same cycle are both honoured.
//     - completed==total_blocks -> DONE (next edge).
//     - DONE: done=1; held until start==0, then -> IDLE with done<=0.
//     - start re-asserted or held while in RUN or DONE has no effect.
//   Assignment regs: core_block_id/core_thread_count hold their value until the next assignment.
//   Reset mid-kernel: immediate return to IDLE, all outputs 0; in-flight blocks are abandoned.
//   Width rules: block_id*THREADS_PER_BLOCK computed in 16 bits; the result fits 8 bits by
//     construction. Counters are 8-bit; no wrap possible since total_blocks<=255.
// STRUCTURE
//   Shared package gpu_pkg: dispatcher state enum (IDLE, RUN, DONE), DATA_W=8 constant.
//   One sub-module: free_core_picker (combinational lowest-index-set priority encoder
//   over the ~busy mask; outputs index + valid). All sequential logic stays in this module.
// TESTING
//   1. thread_count=8, NUM_CORES=2, start=1; cores assert done 5 cycles after core_start ->
//      blocks 0,1 dispatched on consecutive cycles, each with core_thread_count=4; done=1 after
//      both complete.
//   2. thread_count=10 -> 3 blocks; block 2 has core_thread_count=2. It goes to the first core
//      freed, no earlier than 1 cycle after that core's core_reset pulse.
//   3. thread_count=0, start=1 -> no core_start ever; done=1 within 2 cycles; start=0 -> done=0
//      next cycle.
//   4. Both cores assert core_done in the same cycle with 4 blocks (thread_count=16) ->
//      completed +2; both core_reset pulse 1 cycle; blocks 2,3 dispatched on successive cycles.
//   5. Change thread_count to 255 during RUN, and pulse start again -> no effect on the current
//      kernel's block count or done timing.
//   6. Drive reset=0 asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately;
//      after release, a new start with thread_count=4 completes normally.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types and helpers for the GPU front-end blocks.
package gpu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SUM_W  = DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } disp_state_e;

  // Number of blocks needed to cover tc threads, with blocks of 2**tpb_sh threads (rounded up).
  function automatic logic [DATA_W-1:0] calc_total_blocks(input logic [DATA_W-1:0] tc,
                                                          input int unsigned tpb_sh);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(tc) + SUM_W'((1 << tpb_sh) - 1);
    return DATA_W'(sum >> tpb_sh);
  endfunction

endpackage

// File: rtl/free_core_picker.sv
// Combinational priority encoder: index of the lowest-numbered free core.
module free_core_picker #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned IDX_W     = 1
) (
  input  logic [NUM_CORES-1:0] free_i,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 valid_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
      if (free_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_dispatcher.sv
// Splits a kernel into fixed-size thread blocks, hands them to the core array and
// reports completion once every block has been retired.
module block_dispatcher
  import gpu_pkg::*;
#(
  parameter int unsigned NUM_CORES         = 2,
  parameter int unsigned THREADS_PER_BLOCK = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [DATA_W-1:0]           thread_count,
  input  logic [NUM_CORES-1:0]        core_done,
  output logic [NUM_CORES-1:0]        core_start,
  output logic [NUM_CORES-1:0]        core_reset,
  output logic [DATA_W*NUM_CORES-1:0] core_block_id,
  output logic [DATA_W*NUM_CORES-1:0] core_thread_count,
  output logic                        done
);

  localparam int unsigned IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned TPB_SH = $clog2(THREADS_PER_BLOCK);
  localparam int unsigned PROD_W = 16;

  disp_state_e          state_q, state_d;
  logic [DATA_W-1:0]    tc_q, tc_d;
  logic [DATA_W-1:0]    total_q, total_d;
  logic [DATA_W-1:0]    disp_q, disp_d;
  logic [DATA_W-1:0]    comp_q, comp_d;
  logic [NUM_CORES-1:0] run_q, run_d;
  logic [NUM_CORES-1:0] clr_q, clr_d;
  logic [DATA_W-1:0]    bid_q  [NUM_CORES];
  logic [DATA_W-1:0]    bid_d  [NUM_CORES];
  logic [DATA_W-1:0]    tcnt_q [NUM_CORES];
  logic [DATA_W-1:0]    tcnt_d [NUM_CORES];
  logic                 done_q, done_d;

  logic [NUM_CORES-1:0] core_free;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;
  logic [DATA_W-1:0]    n_done;
  logic [PROD_W-1:0]    blk_base;
  logic                 blk_partial;
  logic [DATA_W-1:0]    blk_threads;

  // A core stays busy through its clear pulse and is reusable the cycle after.
  assign core_free = ~(run_q | clr_q);

  free_core_picker #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_picker (
    .free_i  (core_free),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Thread count of the block about to be dispatched; only the last block can be short.
  always_comb begin
    blk_base    = PROD_W'(disp_q) << TPB_SH;
    blk_partial = (disp_q == (total_q - DATA_W'(1))) &&
                  ((PROD_W'(tc_q) & PROD_W'(THREADS_PER_BLOCK - 1)) != '0);
    blk_threads = blk_partial ? DATA_W'(PROD_W'(tc_q) - blk_base)
                              : DATA_W'(THREADS_PER_BLOCK);
  end

  // Next-state: kernel sequencing, completions and dispatch.
  always_comb begin
    state_d = state_q;
    tc_d    = tc_q;
    total_d = total_q;
    disp_d  = disp_q;
    comp_d  = comp_q;
    run_d   = run_q;
    clr_d   = '0;
    bid_d   = bid_q;
    tcnt_d  = tcnt_q;
    done_d  = done_q;
    n_done  = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          tc_d    = thread_count;
          total_d = calc_total_blocks(thread_count, TPB_SH);
          disp_d  = '0;
          comp_d  = '0;
        end
      end

      RUN: begin
        for (int i = 0; i < int'(NUM_CORES); i++) begin
          if (core_done[i] && run_q[i]) begin
            run_d[i] = 1'b0;
            clr_d[i] = 1'b1;
            n_done   = n_done + DATA_W'(1);
          end
        end
        comp_d = comp_q + n_done;

        if (pick_valid && (disp_q < total_q)) begin
          run_d[pick_idx]  = 1'b1;
          bid_d[pick_idx]  = disp_q;
          tcnt_d[pick_idx] = blk_threads;
          disp_d           = disp_q + DATA_W'(1);
        end

        if (comp_q == total_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        if (!start) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tc_q    <= '0;
      total_q <= '0;
      disp_q  <= '0;
      comp_q  <= '0;
      run_q   <= '0;
      clr_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        bid_q[i]  <= '0;
        tcnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      total_q <= total_d;
      disp_q  <= disp_d;
      comp_q  <= comp_d;
      run_q   <= run_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      for (int i = 0; i < int'(NUM_CORES); i++) begin
        bid_q[i]  <= bid_d[i];
        tcnt_q[i] <= tcnt_d[i];
      end
    end
  end

  assign core_start = run_q;
  assign core_reset = clr_q;
  assign done       = done_q;

  for (genvar g = 0; g < int'(NUM_CORES); g++) begin : g_flat
    assign core_block_id[DATA_W*g +: DATA_W]     = bid_q[g];
    assign core_thread_count[DATA_W*g +: DATA_W] = tcnt_q[g];
  end

endmodule

// File: tb/tb_block_dispatcher.sv
// Randomised/directed bench for block_dispatcher with an emulated core array and reference model.
module tb_block_dispatcher;

  localparam int NC  = 2;
  localparam int TPB = 4;
  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [7:0]      thread_count = '0;
  logic [NC-1:0]   core_done = '0;
  logic [NC-1:0]   core_start;
  logic [NC-1:0]   core_reset;
  logic [8*NC-1:0] core_block_id;
  logic [8*NC-1:0] core_thread_count;
  logic            done;

  block_dispatcher #(
    .NUM_CORES         (NC),
    .THREADS_PER_BLOCK (TPB)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .thread_count      (thread_count),
    .core_done         (core_done),
    .core_start        (core_start),
    .core_reset        (core_reset),
    .core_block_id     (core_block_id),
    .core_thread_count (core_thread_count),
    .done              (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: kernel phase, block bookkeeping and what each core is doing.
  int m_phase, m_tc, m_total, m_next, m_fin;
  bit m_run   [NC];
  bit m_pulse [NC];
  int m_bid   [NC];
  int m_cnt   [NC];
  int lat     [NC];
  int lat_cfg [NC];
  bit fuzz;
  bit seen_both;
  int dut_done_step;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE;
    m_tc = 0; m_total = 0; m_next = 0; m_fin = 0;
    for (int i = 0; i < NC; i++) begin
      m_run[i] = 0; m_pulse[i] = 0; m_bid[i] = 0; m_cnt[i] = 0; lat[i] = 0;
    end
  endtask

  function automatic int new_lat(input int c);
    return (lat_cfg[c] > 0) ? lat_cfg[c] : int'($urandom_range(1, 8));
  endfunction

  // What the kernel should look like after the coming clock edge, given current inputs.
  task automatic model_edge();
    bit pulse_n [NC];
    int pick, rem;
    for (int i = 0; i < NC; i++) pulse_n[i] = 0;
    if (m_phase == PH_IDLE) begin
      if (start) begin
        m_phase = PH_RUN;
        m_tc    = int'(thread_count);
        m_total = (m_tc + TPB - 1) / TPB;
        m_next  = 0;
        m_fin   = 0;
      end
    end else if (m_phase == PH_RUN) begin
      if (m_fin == m_total) begin
        m_phase = PH_DONE;
      end else begin
        pick = -1;
        for (int i = NC - 1; i >= 0; i--) if (!m_run[i] && !m_pulse[i]) pick = i;
        for (int i = 0; i < NC; i++) begin
          if (m_run[i] && core_done[i]) begin
            m_run[i] = 0; pulse_n[i] = 1; m_fin++;
          end
        end
        if (pick >= 0 && m_next < m_total) begin
          rem = m_tc - m_next * TPB;
          m_run[pick] = 1;
          m_bid[pick] = m_next;
          m_cnt[pick] = (rem < TPB) ? rem : TPB;
          lat[pick]   = new_lat(pick);
          m_next++;
        end
      end
    end else if (!start) begin
      m_phase = PH_IDLE;
    end
    for (int i = 0; i < NC; i++) m_pulse[i] = pulse_n[i];
  endtask

  // Emulated cores: finish a block after its latency, optionally with stray done on idle cores.
  task automatic drive_cores();
    logic [NC-1:0] cd;
    for (int i = 0; i < NC; i++) begin
      if (m_run[i]) begin
        if (lat[i] > 0) lat[i]--;
        cd[i] = (lat[i] == 0);
      end else begin
        cd[i] = fuzz ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
    end
    core_done = cd;
  endtask

  task automatic check_outputs();
    logic [NC-1:0]   es, er;
    logic [8*NC-1:0] eb, ec;
    for (int i = 0; i < NC; i++) begin
      es[i] = m_run[i];
      er[i] = m_pulse[i];
      eb[8*i +: 8] = 8'(m_bid[i]);
      ec[8*i +: 8] = 8'(m_cnt[i]);
    end
    if (core_reset === '1) seen_both = 1;
    check("core_start",        32'(core_start),        32'(es));
    check("core_reset",        32'(core_reset),        32'(er));
    check("core_block_id",     32'(core_block_id),     32'(eb));
    check("core_thread_count", 32'(core_thread_count), 32'(ec));
    check("done",              32'(done),              32'(m_phase == PH_DONE));
  endtask

  task automatic step();
    drive_cores();
    if (reset) model_edge();
    else       model_reset();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run_kernel(input int tc, input bit disturb);
    int n;
    thread_count  = 8'(tc);
    start         = 1'b1;
    dut_done_step = -1;
    n = 0;
    step();
    n++;
    while (m_phase != PH_DONE && n < 3000) begin
      if (disturb) begin
        thread_count = 8'($urandom_range(0, 255));
        start        = 1'($urandom_range(0, 1));
      end
      step();
      n++;
      if (done === 1'b1 && dut_done_step < 0) dut_done_step = n;
    end
    check("kernel_within_budget", 32'(n < 3000), 32'd1);
    start = 1'b1;
    repeat (2) step();
    start = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    model_reset();
    lat_cfg = '{0, 0};
    fuzz = 0;
    seen_both = 0;

    reset = 1'b0;
    repeat (2) step();
    @(negedge clk);
    reset = 1'b1;
    step();

    lat_cfg = '{5, 5};
    run_kernel(8, 0);

    lat_cfg = '{3, 7};
    run_kernel(10, 0);

    lat_cfg = '{0, 0};
    run_kernel(0, 0);
    check("zero_kernel_done_latency", 32'(dut_done_step >= 1 && dut_done_step <= 2), 32'd1);

    lat_cfg = '{6, 5};
    seen_both = 0;
    run_kernel(16, 0);
    check("simultaneous_core_reset", 32'(seen_both), 32'd1);

    lat_cfg = '{0, 0};
    run_kernel(20, 1);

    // Asynchronous reset in the middle of a running kernel.
    thread_count = 8'd40;
    start = 1'b1;
    repeat (12) step();
    #3 reset = 1'b0;
    #1;
    check("async_rst_core_start",    32'(core_start),        32'd0);
    check("async_rst_core_reset",    32'(core_reset),        32'd0);
    check("async_rst_block_id",      32'(core_block_id),     32'd0);
    check("async_rst_thread_count",  32'(core_thread_count), 32'd0);
    check("async_rst_done",          32'(done),              32'd0);
    model_reset();
    start = 1'b0;
    core_done = '0;
    step();
    #3 reset = 1'b1;
    step();
    run_kernel(4, 0);

    run_kernel(255, 0);
    run_kernel(253, 0);
    run_kernel(1, 0);

    repeat (15) begin
      fuzz = 1'($urandom_range(0, 1));
      run_kernel(int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
